muldiv_unit: RTL
================

# muldiv_unit

Iterative unsigned multiply/divide unit in the execute stage. It sits directly downstream of the 32-bit ALU-operand 2:1 multiplexer and takes its operands from that mux output. It performs one shift-add or shift-subtract step per clock, so a multiply or divide takes a fixed 32 cycles. It uses a start/busy/done handshake and holds the result until the next operation is accepted.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: operation request, sampled on `clk` rising edge.
- `op`, input, 2: operation select. 00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder).
- `a`, input, WIDTH: operand A / dividend, from the operand mux.
- `b`, input, WIDTH: operand B / divisor, from the operand mux.
- `busy`, output, 1: high while iterating.
- `done`, output, 1: one-cycle pulse; `result` is valid.
- `result`, output, WIDTH: selected result, held until the next accepted `start`.

## Operation
- FSM states:
  - IDLE: no operation in progress.
  - RUN: iterating.
  - DONE: result valid.
- Outputs from state: `busy` = (state==RUN); `done` = (state==DONE).
- Accept rule: `start` is accepted when state is IDLE or DONE. In RUN, `start` is ignored and `a`/`b`/`op` are not re-sampled.
- On accept: latch `a`, `b` and `op`; clear the 2·WIDTH accumulator; step counter = 0; go to RUN.
- MUL/MULHU: shift-add over the latched `b` bits, LSB first, into a 2·WIDTH product.
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2·WIDTH-1:WIDTH].
- DIVU/REMU: restoring division, MSB first; each step is compare-and-subtract on a WIDTH+1-bit partial remainder.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: no special case. The natural restoring result is required: quotient = all-ones, remainder = `a`.
- Counter: increments every RUN cycle. At count WIDTH-1, go to DONE and register `result`.
- DONE: lasts exactly one cycle, then IDLE, unless `start` is high, in which case go straight back to RUN.
- Arithmetic: unsigned only; all intermediate widths are exact, with no truncation before final selection.

## Timing
- Reset values: state IDLE, counter 0, `busy` 0, `done` 0, `result` 0, operand latches 0.
- `start` accepted at edge N:
  - `busy`=1 after edge N.
  - Iteration steps occur at edges N+1 … N+32.
  - `done`=1 and `result` valid after edge N+32.
  - `busy` is 0 during the DONE cycle.
- Latency: 32 cycles from the accepting edge to `done`. Throughput: one operation per 33 cycles back-to-back.
- `result` remains stable from the `done` cycle until the edge after the next accepted `start`, where it is not cleared and only updates at the next DONE.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs to reset values, operation discarded; no `done` pulse.
- Operand changes during RUN: no effect on the in-flight operation.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: full divider datapath; all four ops as above.
- Undefined:
  - Divider logic is not compiled.
  - op 10/11 is still accepted, but goes IDLE→DONE in one cycle with `result` = 0; `busy` stays 0.
  - MUL/MULHU behaviour is unchanged.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings `OP_MUL`, `OP_MULHU`, `OP_DIVU`, `OP_REMU`;
  - FSM state typedef (IDLE/RUN/DONE);
  - default `WIDTH` and counter-width constant clog2(WIDTH).
- One sub-module, `muldiv_step`: combinational single iteration (shift-add or compare-subtract) selected by the latched op. The top holds the FSM, counter and registers.

## Test plan
- MUL a=7, b=6: `done` exactly 32 cycles after the accepting edge, `result`=42; `busy` high for exactly 32 cycles.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → `result`=0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIVU a=100, b=7 → 14; REMU same operands → 2; DIVU a=0x80000000, b=1 → 0x80000000.
- Divide by zero: DIVU a=5, b=0 → 0xFFFFFFFF; REMU a=5, b=0 → 5. With `MULDIV_DIV_EN` undefined: `done` 1 cycle after accept, `result`=0.
- Ignore and back-to-back:
  - `start` pulsed at RUN cycle 10 with a new op → ignored; the original result is unchanged.
  - `start` held during DONE → new op accepted, `busy` reasserted the next cycle.
- Reset: `rst_n` dropped asynchronously at RUN cycle 10 → `busy`/`done`/`result` = 0 immediately; no `done` after release until a new `start`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Optional divider datapath is selected with the MULDIV_DIV_EN macro.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // True for the two divider operations.
    function automatic logic is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Accumulator layout is shared by both paths: the upper half holds the
// high product word / partial remainder, the lower half the low product
// word / quotient. Divider path only exists when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic [1:0]         op,
    input  logic [CNTW-1:0]    cnt,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] addend_s;
    logic [2*WIDTH-1:0] mul_s;

    // Shift-add: add a<<cnt into the full-width product when b[cnt] is set.
    always_comb begin
        addend_s = {(2*WIDTH){1'b0}};
        if (b[cnt]) begin
            addend_s = {{WIDTH{1'b0}}, a} << cnt;
        end else begin
            addend_s = {(2*WIDTH){1'b0}};
        end
        mul_s = acc + addend_s;
    end

`ifdef MULDIV_DIV_EN
    logic [CNTW-1:0]  idx_s;
    logic [WIDTH:0]   partial_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_s;
    logic             qbit_s;
    logic [2*WIDTH-1:0] div_s;

    // Restoring division step: bring down the next dividend bit (MSB first),
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // naturally yields an all-ones quotient and remainder equal to a.
    always_comb begin
        idx_s     = CNTW'(WIDTH - 1) - cnt;
        partial_s = {acc[2*WIDTH-1:WIDTH], a[idx_s]};
        diff_s    = partial_s - {1'b0, b};
        qbit_s    = (partial_s >= {1'b0, b});
        if (qbit_s) begin
            rem_s = diff_s[WIDTH-1:0];
        end else begin
            rem_s = partial_s[WIDTH-1:0];
        end
        div_s = {rem_s, acc[WIDTH-2:0], qbit_s};
    end
`endif

    // Pick the iteration result for the latched operation.
    always_comb begin
        acc_next = acc;
        case (op)
            OP_MUL, OP_MULHU: acc_next = mul_s;
`ifdef MULDIV_DIV_EN
            OP_DIVU, OP_REMU: acc_next = div_s;
`endif
            default:          acc_next = acc;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one step per clock, 32-cycle
// latency, start/busy/done handshake. Macro MULDIV_DIV_EN enables the
// divider; without it divide ops complete immediately with a zero result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNTW = $clog2(WIDTH);

    state_t             state_r;
    state_t             state_next_s;
    logic               accept_s;
    logic               last_s;
    logic [CNTW-1:0]    cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]   sel_s;
    logic [WIDTH-1:0]   result_r;

    assign last_s = (cnt_r == CNTW'(WIDTH - 1));
    assign busy   = (state_r == RUN);
    assign done   = (state_r == DONE);
    assign result = result_r;

    muldiv_step #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_step (
        .op       (op_r),
        .cnt      (cnt_r),
        .a        (a_r),
        .b        (b_r),
        .acc      (acc_r),
        .acc_next (acc_next_s)
    );

    // Next-state logic; a new op is accepted only from IDLE or DONE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s = 1'b1;
`ifdef MULDIV_DIV_EN
                    state_next_s = RUN;
`else
                    if (is_div(op)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Final result selection from the accumulator after the last step.
    always_comb begin
        sel_s = acc_next_s[WIDTH-1:0];
        case (op_r)
            OP_MUL, OP_DIVU:   sel_s = acc_next_s[WIDTH-1:0];
            OP_MULHU, OP_REMU: sel_s = acc_next_s[2*WIDTH-1:WIDTH];
            default:           sel_s = acc_next_s[WIDTH-1:0];
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latches, accumulator, step counter and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            op_r     <= 2'b00;
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNTW{1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            acc_r <= {(2*WIDTH){1'b0}};
            cnt_r <= {CNTW{1'b0}};
`ifndef MULDIV_DIV_EN
            if (is_div(op)) begin
                result_r <= {WIDTH{1'b0}};
            end
`endif
        end else if (state_r == RUN) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNTW'(1);
            if (last_s) begin
                result_r <= sel_s;
            end
        end
    end

endmodule
